// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the AES-192 decrypt key schedule.
package aes_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NK     = 6;
    localparam int unsigned NR     = 12;

    typedef enum logic [1:0] {IDLE, FWD, EMIT, BWD} state_e;

    // Forward S-box, byte 0x00 at the most significant end.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_subrot_word.sv
// SubWord(RotWord(x)): rotate left one byte, then four parallel S-box lookups.
module aes_subrot_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] y_o
);

    logic [WORD_W-1:0] rot;

    assign rot = {x_i[23:0], x_i[31:24]};
    assign y_o = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

// File: rtl/aes192_dec_key_sched.sv
// AES-192 decrypt key schedule: forward expansion into a 6-word window, then backward replay emitting rounds 12..0.
// Optional AES_DEC_KEY_SELFCHECK_EN adds a key shadow and chk_err comparing the rewound window to the loaded key.
module aes192_dec_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [0:191] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         busy
`ifdef AES_DEC_KEY_SELFCHECK_EN
    ,
    output logic         chk_err
`endif
);

    localparam logic [5:0] J_FWD_LAST = 6'(4 * (NR + 1) - NK - 1);

    state_e                 state_q, state_d;
    logic [0:5][WORD_W-1:0] win_q, win_d;
    logic [5:0]             j_q, j_d;
    logic [3:0]             r_q, r_d;
    logic [1:0]             step_q, step_d;

    logic                   rk_valid_q, rk_valid_d;
    logic [0:127]           rk_q, rk_d;
    logic [3:0]             rk_round_q, rk_round_d;
    logic                   rk_last_q, rk_last_d;

    logic [5:0]             idx;
    logic [WORD_W-1:0]      sub_in, sub_out, mix, fresh;

    // FWD derives w[j+6] from w[j+5]; BWD recovers w[j-1] using w[j+4]. Both need g() on one word.
    assign idx    = (state_q == BWD) ? j_q + 6'd5 : j_q + 6'd6;
    assign sub_in = (state_q == BWD) ? win_q[4] : win_q[5];

    aes_subrot_word u_subrot (
        .x_i (sub_in),
        .y_o (sub_out)
    );

    always_comb begin
        mix = sub_in;
        if (idx % 6'd6 == 6'd0) begin
            mix = sub_out ^ {rcon(4'(idx / 6'd6)), 24'h0};
        end
        fresh = ((state_q == BWD) ? win_q[5] : win_q[0]) ^ mix;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        j_d     = j_q;
        r_d     = r_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    win_d   = key;
                    j_d     = '0;
                    r_d     = 4'(NR);
                    state_d = FWD;
                end
            end
            FWD: begin
                win_d = {win_q[1:5], fresh};
                j_d   = j_q + 6'd1;
                if (j_q == J_FWD_LAST) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (r_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        r_d     = r_q - 4'd1;
                        step_d  = (r_q == 4'd1) ? 2'd1 : 2'd3;
                        state_d = BWD;
                    end
                end
            end
            BWD: begin
                win_d = {fresh, win_q[0:4]};
                j_d   = j_q - 6'd1;
                if (step_q == 2'd0) begin
                    state_d = EMIT;
                end else begin
                    step_d = step_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they are valid in the first EMIT cycle.
    always_comb begin
        rk_valid_d = (state_d == EMIT);
        rk_d       = '0;
        rk_round_d = '0;
        rk_last_d  = 1'b0;
        if (rk_valid_d) begin
            rk_d       = (r_d == 4'd0) ? win_d[0:3] : win_d[2:5];
            rk_round_d = r_d;
            rk_last_d  = (r_d == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            j_q        <= '0;
            r_q        <= '0;
            step_q     <= '0;
            rk_valid_q <= 1'b0;
            rk_q       <= '0;
            rk_round_q <= '0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            j_q        <= j_d;
            r_q        <= r_d;
            step_q     <= step_d;
            rk_valid_q <= rk_valid_d;
            rk_q       <= rk_d;
            rk_round_q <= rk_round_d;
            rk_last_q  <= rk_last_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk        = rk_q;
    assign rk_round  = rk_round_q;
    assign rk_last   = rk_last_q;

`ifdef AES_DEC_KEY_SELFCHECK_EN
    logic [0:5][WORD_W-1:0] shadow_q;
    logic                   chk_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '0;
            chk_err_q <= 1'b0;
        end else if (state_q == IDLE && key_valid) begin
            shadow_q  <= key;
            chk_err_q <= 1'b0;
        end else if (state_q == EMIT && rk_ready && r_q == 4'd0) begin
            chk_err_q <= (win_q != shadow_q);
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_aes192_dec_key_sched.sv
// Directed bench for aes192_dec_key_sched: FIPS-197 A.2 vectors, backpressure, busy rejection, reset, back-to-back.
module tb_aes192_dec_key_sched;
    import aes_pkg::*;

    localparam logic [0:191] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [0:191] KEY_B  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [0:191] KEY_C  = 192'hffeeddccbbaa99887766554433221100a5a55a5a3c3cc3c3;
    localparam logic [0:191] KEY_D  = 192'h0123456789abcdeffedcba98765432100f1e2d3c4b5a6978;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [0:191] key = '0;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic [0:127] rk;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;
`ifdef AES_DEC_KEY_SELFCHECK_EN
    logic         chk_err;
`endif

    aes192_dec_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
`ifdef AES_DEC_KEY_SELFCHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int           round;
        logic [127:0] rk;
        logic         last;
    } vec_t;
    vec_t tbl[3];

    logic [31:0]  ref_w [52];
    logic [127:0] got_rk [13];
    logic         got_last [13];

    function automatic logic [31:0] sub4(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Plain full-length forward expansion; round keys are read straight out of it.
    task automatic expand(input logic [0:191] k);
        logic [31:0] t;
        for (int i = 0; i < 6; i++) ref_w[i] = k[32*i +: 32];
        for (int i = 6; i < 52; i++) begin
            t = ref_w[i-1];
            if (i % 6 == 0) t = sub4({t[23:0], t[31:24]}) ^ {rcon(4'(i / 6)), 24'h0};
            ref_w[i] = ref_w[i-6] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Called at a negedge with the block idle; leaves the bench at the first rk_valid cycle.
    task automatic accept_and_wait(input logic [0:191] k);
        expand(k);
        key_valid = 1'b1;
        key       = k;
        check_int("accept_key_ready", int'(key_ready), 1);
        @(negedge clk);
        key_valid = 1'b0;
        check_int("busy_after_accept", int'(busy), 1);
        repeat (45) @(negedge clk);
        check_int("rk_valid_early", int'(rk_valid), 0);
        @(negedge clk);
        check_int("rk_valid_lat47", int'(rk_valid), 1);
    endtask

    task automatic collect(input int stall_round, input int stall_len, input bit poke, input int abort_round);
        int exp_r, guard, held, last_cyc, nvalid;
        bit first;
        exp_r = 12; guard = 0; held = 0; last_cyc = 0; first = 1'b1;
        rk_ready = 1'b1;
        while (exp_r >= 0) begin
            if (guard > 3000) begin
                check_int("collect_timeout", exp_r, -1);
                return;
            end
            key_valid = 1'b0;
            if (rk_valid) begin
                if (first) begin
                    if (stall_round < 0 && exp_r < 12)
                        check_int("key_spacing", cyc - last_cyc, (exp_r == 0) ? 3 : 5);
                    last_cyc = cyc;
                    first = 1'b0;
                    got_rk[exp_r]   = rk;
                    got_last[exp_r] = rk_last;
                end
                check_vec("rk", rk, ref_rk(exp_r));
                check_int("rk_round", int'(rk_round), exp_r);
                check_int("rk_last", int'(rk_last), (exp_r == 0) ? 1 : 0);
                if (exp_r == abort_round) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_int("abort_rk_valid", int'(rk_valid), 0);
                    check_int("abort_key_ready", int'(key_ready), 1);
                    nvalid = 0;
                    repeat (60) begin
                        @(negedge clk);
                        if (rk_valid) nvalid++;
                    end
                    check_int("abort_no_emit", nvalid, 0);
                    return;
                end
                if (exp_r == stall_round && held < stall_len) begin
                    rk_ready = 1'b0;
                    held++;
                end else begin
                    rk_ready = 1'b1;
                    exp_r--;
                    first = 1'b1;
                end
            end else if (poke && exp_r == 9) begin
                key_valid = 1'b1;
                key       = KEY_A2;
                check_int("busy_key_ready", int'(key_ready), 0);
            end
            @(negedge clk);
            guard++;
        end
        rk_ready = 1'b1;
        check_int("post_last_rk_valid", int'(rk_valid), 0);
        check_int("post_last_key_ready", int'(key_ready), 1);
    endtask

    initial begin
        tbl[0] = '{12, 128'he98ba06f448c773c8ecc720401002202, 1'b0};
        tbl[1] = '{1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b0};
        tbl[2] = '{0,  128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1};
        for (int i = 0; i < 13; i++) begin
            got_rk[i]   = '0;
            got_last[i] = 1'b0;
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_int("rst_rk_valid", int'(rk_valid), 0);
        check_vec("rst_rk", rk, '0);
        check_int("rst_rk_round", int'(rk_round), 0);
        check_int("rst_rk_last", int'(rk_last), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_key_ready", int'(key_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        accept_and_wait(KEY_A2);
        collect(-1, 0, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            check_vec("a2_table_rk", got_rk[tbl[i].round], tbl[i].rk);
            check_int("a2_table_last", int'(got_last[tbl[i].round]), int'(tbl[i].last));
        end
`ifdef AES_DEC_KEY_SELFCHECK_EN
        check_int("chk_err_clean", int'(chk_err), 0);
`endif

        // Back-to-back acceptance in the cycle after the round-0 handshake, with a stall at round 7.
        accept_and_wait(KEY_B);
        collect(7, 10, 1'b0, -1);

        accept_and_wait(KEY_C);
        collect(-1, 0, 1'b1, -1);

        accept_and_wait(KEY_D);
        collect(-1, 0, 1'b0, 5);

        accept_and_wait(KEY_A2);
        collect(-1, 0, 1'b0, -1);

`ifdef AES_DEC_KEY_SELFCHECK_EN
        begin
            logic [0:5][31:0] tmp;
            int g;
            accept_and_wait(KEY_B);
            rk_ready = 1'b1;
            g = 0;
            while (!(rk_valid && rk_round == 4'd6) && g < 200) begin
                @(negedge clk);
                g++;
            end
            check_int("inj_reach_r6", int'(rk_round), 6);
            @(negedge clk);
            tmp = dut.win_q;
            tmp[0][0] = ~tmp[0][0];
            force dut.win_q = tmp;
            #1 release dut.win_q;
            g = 0;
            while (!(rk_valid && rk_last) && g < 200) begin
                @(negedge clk);
                g++;
            end
            check_int("inj_reach_last", int'(rk_last), 1);
            @(negedge clk);
            check_int("chk_err_flip", int'(chk_err), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
